wb_regfile: RTL and testbench

//  Write-back stage and architectural register file. Consumes the MEM/WB pipeline outputs
//  and commits results through a single write port, up to two writes per instruction.
//  Two-write instructions (mul/div high word, swap) are sequenced by a 2-state FSM that

---
 rtl/wb_regfile_if.sv | 26 ++
 rtl/wb_regfile.sv | 122 ++++++++++++
 tb/tb_wb_regfile.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back bus between the pipeline (master) and the register file (slave).
// wbStall flows back to the pipeline to hold IF..MEM/WB for one cycle.
interface wb_regfile_if #(
   parameter int DW = 16,
   parameter int AW = 4
) ();
   logic [DW-1:0] wbMemRD;
   logic [DW-1:0] wbALUout;
   logic [DW-1:0] wbRD1;
   logic [DW-1:0] wbRD15;
   logic [AW-1:0] wbOP1;
   logic [AW-1:0] wbOP2;
   logic [2:0]    wbRegWrite;
   logic          wbF;
   logic          wbStall;

   modport master (
      output wbMemRD, wbALUout, wbRD1, wbRD15, wbOP1, wbOP2, wbRegWrite, wbF,
      input  wbStall
   );

   modport slave (
      input  wbMemRD, wbALUout, wbRD1, wbRD15, wbOP1, wbOP2, wbRegWrite, wbF,
      output wbStall
   );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: one write port, two-write commands
// sequenced over two edges with a one-cycle stall, two bypassed async read ports, flag register.
module wb_regfile #(
   parameter int DW     = 16,
   parameter int AW     = 4,
   parameter int NREG   = 2**AW,
   parameter int HI_REG = 15
) (
   input  logic          clk,
   input  logic          reset,
   wb_regfile_if.slave   wb,
   input  logic [AW-1:0] raddrA,
   input  logic [AW-1:0] raddrB,
   output logic [DW-1:0] rdataA,
   output logic [DW-1:0] rdataB,
   output logic          flag
);

   localparam logic [AW-1:0] HI_ADDR = AW'(HI_REG);

   typedef enum logic {IDLE, SECOND} stateT;

   stateT         state, nextState;
   logic [DW-1:0] regs [NREG];
   logic [AW-1:0] pendAddr;
   logic [DW-1:0] pendData;

   logic          firstWrite, twoWrite, flagEn, latchPend;
   logic [DW-1:0] firstData, secData;
   logic [AW-1:0] secAddr;
   logic          wrEn;
   logic [AW-1:0] wrAddr;
   logic [DW-1:0] wrData;

   // Command decode; reserved encodings fall through to "no write".
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      firstWrite = 1'b0;
      twoWrite   = 1'b0;
      firstData  = wb.wbALUout;
      secAddr    = '0;
      secData    = '0;
      case (wb.wbRegWrite)
         3'b001: firstWrite = 1'b1;
         3'b010: begin
            firstWrite = 1'b1;
            firstData  = wb.wbMemRD;
         end
         3'b011: begin
            firstWrite = 1'b1;
            twoWrite   = 1'b1;
            secAddr    = HI_ADDR;
            secData    = wb.wbRD15;
         end
         3'b100: begin
            firstWrite = 1'b1;
            twoWrite   = 1'b1;
            secAddr    = wb.wbOP2;
            secData    = wb.wbRD1;
         end
         default: ;
      endcase
   end

   // Next state and the single write port; held inputs are ignored while in SECOND.
   always_comb begin
      nextState  = state;
      wrEn       = 1'b0;
      wrAddr     = wb.wbOP1;
      wrData     = firstData;
      flagEn     = 1'b0;
      latchPend  = 1'b0;
      wb.wbStall = 1'b0;
      if (reset) begin
         case (state)
            IDLE: begin
               wrEn      = firstWrite;
               flagEn    = firstWrite;
               latchPend = twoWrite;
               if (twoWrite) begin
                  wb.wbStall = 1'b1;
                  nextState  = SECOND;
               end
            end
            SECOND: begin
               wrEn      = 1'b1;
               wrAddr    = pendAddr;
               wrData    = pendData;
               nextState = IDLE;
            end
            default: nextState = IDLE;
         endcase
      end
   end

   // Reads see the write that commits at the coming edge.
   always_comb begin
      rdataA = (wrEn && (wrAddr == raddrA)) ? wrData : regs[raddrA];
      rdataB = (wrEn && (wrAddr == raddrB)) ? wrData : regs[raddrB];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         pendAddr <= '0;
         pendData <= '0;
         flag     <= 1'b0;
         // NOTE: the array is reset because reads must return 0 after reset; this rules out a RAM macro.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state <= nextState;
         if (wrEn)   regs[wrAddr] <= wrData;
         if (flagEn) flag         <= wb.wbF;
         if (latchPend) begin
            pendAddr <= secAddr;
            pendData <= secData;
         end
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: single/two-write commands, stall timing, bypass,
// same-address ordering, reserved commands and asynchronous reset.
module tb_wb_regfile;
   localparam int DW = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] raddrA, raddrB;
   logic [DW-1:0] rdataA, rdataB;
   logic          flag;
   int            passCount = 0;
   int            totalCount = 0;

   wb_regfile_if #(.DW(DW), .AW(AW)) wb ();

   wb_regfile #(.DW(DW), .AW(AW), .NREG(16), .HI_REG(15)) dut (
      .clk    (clk),
      .reset  (reset),
      .wb     (wb.slave),
      .raddrA (raddrA),
      .raddrB (raddrB),
      .rdataA (rdataA),
      .rdataB (rdataB),
      .flag   (flag)
   );

   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic setCmd(input logic [2:0] cmd, input logic [AW-1:0] op1, input logic [AW-1:0] op2,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic [DW-1:0] rd1,
                         input logic [DW-1:0] rd15, input logic f);
      wb.wbRegWrite = cmd;
      wb.wbOP1      = op1;
      wb.wbOP2      = op2;
      wb.wbALUout   = alu;
      wb.wbMemRD    = mem;
      wb.wbRD1      = rd1;
      wb.wbRD15     = rd15;
      wb.wbF        = f;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      setCmd(3'b000, '0, '0, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic test_reset();
      raddrA = 4'd3;
      raddrB = 4'd15;
      #1;
      totalCount++;
      if (rdataA !== 16'h0000) $display("FAIL reset_rdataA got=%h exp=0000", rdataA); else passCount++;
      totalCount++;
      if (rdataB !== 16'h0000) $display("FAIL reset_rdataB got=%h exp=0000", rdataB); else passCount++;
      totalCount++;
      if (flag !== 1'b0) $display("FAIL reset_flag got=%b exp=0", flag); else passCount++;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", wb.wbStall); else passCount++;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      setCmd(3'b001, 4'd3, 4'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1);
      #1;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL single_stall got=%b exp=0", wb.wbStall); else passCount++;
      tick();
      idle();
      raddrA = 4'd3;
      #1;
      totalCount++;
      if (rdataA !== 16'h1234) $display("FAIL single_R3 got=%h exp=1234", rdataA); else passCount++;
      totalCount++;
      if (flag !== 1'b1) $display("FAIL single_flag got=%b exp=1", flag); else passCount++;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL single_stall_after got=%b exp=0", wb.wbStall); else passCount++;
   endtask

   task automatic test_hiword();
      setCmd(3'b011, 4'd2, 4'd0, 16'h0005, 16'h0000, 16'h0000, 16'hABCD, 1'b0);
      #1;
      totalCount++;
      if (wb.wbStall !== 1'b1) $display("FAIL hi_stall_c1 got=%b exp=1", wb.wbStall); else passCount++;
      tick();
      // Instruction still held in MEM/WB; a changed ALU value must not reach R2.
      wb.wbALUout = 16'h9999;
      raddrA = 4'd2;
      raddrB = 4'd15;
      #1;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL hi_stall_c2 got=%b exp=0", wb.wbStall); else passCount++;
      totalCount++;
      if (rdataA !== 16'h0005) $display("FAIL hi_R2_after_edge1 got=%h exp=0005", rdataA); else passCount++;
      totalCount++;
      if (rdataB !== 16'hABCD) $display("FAIL hi_R15_bypass got=%h exp=abcd", rdataB); else passCount++;
      totalCount++;
      if (flag !== 1'b0) $display("FAIL hi_flag got=%b exp=0", flag); else passCount++;
      tick();
      idle();
      #1;
      totalCount++;
      if (rdataA !== 16'h0005) $display("FAIL hi_R2_final got=%h exp=0005", rdataA); else passCount++;
      totalCount++;
      if (rdataB !== 16'hABCD) $display("FAIL hi_R15_final got=%h exp=abcd", rdataB); else passCount++;
   endtask

   task automatic test_swap();
      setCmd(3'b100, 4'd4, 4'd5, 16'h00AA, 16'h0000, 16'h00BB, 16'h0000, 1'b1);
      raddrA = 4'd4;
      raddrB = 4'd5;
      #1;
      totalCount++;
      if (wb.wbStall !== 1'b1) $display("FAIL swap_stall_c1 got=%b exp=1", wb.wbStall); else passCount++;
      totalCount++;
      if (rdataA !== 16'h00AA) $display("FAIL swap_R4_bypass got=%h exp=00aa", rdataA); else passCount++;
      tick();
      #1;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL swap_stall_c2 got=%b exp=0", wb.wbStall); else passCount++;
      totalCount++;
      if (rdataB !== 16'h00BB) $display("FAIL swap_R5_bypass_second got=%h exp=00bb", rdataB); else passCount++;
      totalCount++;
      if (rdataA !== 16'h00AA) $display("FAIL swap_R4_edge1 got=%h exp=00aa", rdataA); else passCount++;
      totalCount++;
      if (flag !== 1'b1) $display("FAIL swap_flag got=%b exp=1", flag); else passCount++;
      tick();
      idle();
      #1;
      totalCount++;
      if (rdataB !== 16'h00BB) $display("FAIL swap_R5_final got=%h exp=00bb", rdataB); else passCount++;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL swap_stall_after got=%b exp=0", wb.wbStall); else passCount++;
   endtask

   task automatic test_same_addr();
      setCmd(3'b011, 4'd15, 4'd0, 16'h0001, 16'h0000, 16'h0000, 16'h0002, 1'b1);
      tick();
      tick();
      idle();
      raddrA = 4'd15;
      #1;
      totalCount++;
      if (rdataA !== 16'h0002) $display("FAIL same_hi_R15 got=%h exp=0002", rdataA); else passCount++;
      setCmd(3'b100, 4'd6, 4'd6, 16'h0011, 16'h0000, 16'h0022, 16'h0000, 1'b1);
      tick();
      tick();
      idle();
      raddrA = 4'd6;
      #1;
      totalCount++;
      if (rdataA !== 16'h0022) $display("FAIL same_swap_R6 got=%h exp=0022", rdataA); else passCount++;
   endtask

   task automatic test_reserved();
      // flag is 1 here; reserved commands must leave it and R3 alone.
      for (int c = 5; c <= 7; c++) begin
         setCmd(3'(c), 4'd3, 4'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
         raddrA = 4'd3;
         raddrB = 4'd15;
         #1;
         totalCount++;
         if (wb.wbStall !== 1'b0) $display("FAIL reserved_stall cmd=%0d got=%b exp=0", c, wb.wbStall); else passCount++;
         tick();
         #1;
         totalCount++;
         if (rdataA !== 16'h1234) $display("FAIL reserved_R3 cmd=%0d got=%h exp=1234", c, rdataA); else passCount++;
         totalCount++;
         if (rdataB !== 16'h0002) $display("FAIL reserved_R15 cmd=%0d got=%h exp=0002", c, rdataB); else passCount++;
         totalCount++;
         if (flag !== 1'b1) $display("FAIL reserved_flag cmd=%0d got=%b exp=1", c, flag); else passCount++;
      end
      idle();
   endtask

   task automatic test_bypass();
      setCmd(3'b010, 4'd7, 4'd0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0);
      raddrA = 4'd7;
      raddrB = 4'd8;
      #1;
      totalCount++;
      if (rdataA !== 16'hBEEF) $display("FAIL bypass_R7_pre got=%h exp=beef", rdataA); else passCount++;
      totalCount++;
      if (rdataB !== 16'h0000) $display("FAIL bypass_R8_unrelated got=%h exp=0000", rdataB); else passCount++;
      tick();
      setCmd(3'b001, 4'd0, 4'd0, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000, 1'b1);
      tick();
      idle();
      raddrB = 4'd0;
      #1;
      totalCount++;
      if (rdataA !== 16'hBEEF) $display("FAIL bypass_R7_stored got=%h exp=beef", rdataA); else passCount++;
      totalCount++;
      if (rdataB !== 16'h5A5A) $display("FAIL write_R0 got=%h exp=5a5a", rdataB); else passCount++;
      totalCount++;
      if (flag !== 1'b1) $display("FAIL mem_write_flag got=%b exp=1", flag); else passCount++;
   endtask

   task automatic test_reset_mid();
      setCmd(3'b100, 4'd8, 4'd9, 16'h1111, 16'h0000, 16'h2222, 16'h0000, 1'b1);
      tick();
      // Now in SECOND with R9 pending; reset must act without waiting for an edge.
      raddrA = 4'd8;
      raddrB = 4'd9;
      #1;
      reset = 1'b0;
      #1;
      totalCount++;
      if (rdataA !== 16'h0000) $display("FAIL midreset_R8 got=%h exp=0000", rdataA); else passCount++;
      totalCount++;
      if (rdataB !== 16'h0000) $display("FAIL midreset_R9 got=%h exp=0000", rdataB); else passCount++;
      totalCount++;
      if (flag !== 1'b0) $display("FAIL midreset_flag got=%b exp=0", flag); else passCount++;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL midreset_stall got=%b exp=0", wb.wbStall); else passCount++;
      idle();
      @(negedge clk);
      reset = 1'b1;
      tick();
      totalCount++;
      if (rdataB !== 16'h0000) $display("FAIL midreset_pending_dropped got=%h exp=0000", rdataB); else passCount++;
      setCmd(3'b001, 4'd9, 4'd0, 16'h0777, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      #1;
      totalCount++;
      if (wb.wbStall !== 1'b0) $display("FAIL postreset_stall got=%b exp=0", wb.wbStall); else passCount++;
      tick();
      idle();
      #1;
      totalCount++;
      if (rdataB !== 16'h0777) $display("FAIL postreset_R9 got=%h exp=0777", rdataB); else passCount++;
   endtask

   initial begin
      reset  = 1'b0;
      raddrA = '0;
      raddrB = '0;
      idle();
      test_reset();
      test_single();
      test_hiword();
      test_swap();
      test_same_addr();
      test_reserved();
      test_bypass();
      test_reset_mid();
      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end
endmodule
